// File: rtl/rv32i_pkg.sv
// Shared definitions for the rv32i boot path: loader states and framing constants.
package rv32i_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CHK,
    DONE,
    ERR
  } loaderState_t;

  localparam logic [7:0] LOADER_MAGIC = 8'hA5;
  localparam int         WORD_BYTES   = 4;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs accepted payload bytes (LSB first) into 32-bit words.
// wordDone and word are combinational on the fourth byte's transfer so the
// loader can register the write on that same edge.
module word_assembler
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byteIn,
  input  logic        byteXfer,
  output logic        wordDone,
  output logic [31:0] word
);

  logic [1:0]  lane;
  logic [31:0] shiftReg;

  // Shift each accepted byte in from the top; after four bytes b0 sits in [7:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane     <= 2'd0;
      shiftReg <= 32'd0;
    end else if (byteXfer) begin
      lane     <= lane + 2'd1;
      shiftReg <= {byteIn, shiftReg[31:8]};
    end
  end

  assign wordDone = byteXfer && (lane == 2'(WORD_BYTES - 1));
  assign word     = {byteIn, shiftReg[31:8]};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a framed byte image (MAGIC, LEN, payload, XOR checksum)
// and writes it into instruction memory, releasing the core only on a clean load.
//
// state | meaning
// IDLE  | hunting for MAGIC, other bytes dropped
// LEN0  | expecting LEN[7:0]
// LEN1  | expecting LEN[15:8], range-checked here
// DATA  | payload bytes, one memory write per four bytes
// CHK   | expecting the checksum byte
// DONE  | image good, core running, input closed
// ERR   | frame rejected, core held, input closed
module imem_loader
  import rv32i_pkg::*;
#(
  parameter int         IMEM_WORDS = 64,
  parameter int         ADDR_W     = 16,
  parameter logic [7:0] MAGIC      = LOADER_MAGIC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        byteIn,
  input  logic              byteValid,
  output logic              byteReady,
  output logic              imemWe,
  output logic [ADDR_W-1:0] imemAddr,
  output logic [31:0]       imemWdata,
  output logic              coreRun,
  output logic              loadErr,
  output logic [ADDR_W-1:0] wordCount
);

  loaderState_t      state;
  logic [7:0]        lenLo;
  logic [15:0]       lenWords;
  logic [7:0]        checksum;
  logic              xfer;
  logic              dataXfer;
  logic              wordDone;
  logic [31:0]       asmWord;
  logic [15:0]       lenNext;
  logic [ADDR_W-1:0] wcNext;

  // Ready is a pure function of state; reset gating keeps it low while rst_n is held.
  assign byteReady = rst_n && (state inside {IDLE, LEN0, LEN1, DATA, CHK});
  assign xfer      = byteValid && byteReady;
  assign dataXfer  = xfer && (state == DATA);
  assign lenNext   = {byteIn, lenLo};
  assign wcNext    = wordCount + 1'b1;

  word_assembler uAsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .byteIn   (byteIn),
    .byteXfer (dataXfer),
    .wordDone (wordDone),
    .word     (asmWord)
  );

  // Frame FSM with registered write strobe, address counter, checksum and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lenLo     <= 8'd0;
      lenWords  <= 16'd0;
      checksum  <= 8'd0;
      imemWe    <= 1'b0;
      imemAddr  <= '0;
      imemWdata <= 32'd0;
      coreRun   <= 1'b0;
      loadErr   <= 1'b0;
      wordCount <= '0;
    end else begin
      imemWe <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer && byteIn == MAGIC) state <= LEN0;
        end
        LEN0: begin
          if (xfer) begin
            lenLo <= byteIn;
            state <= LEN1;
          end
        end
        LEN1: begin
          if (xfer) begin
            lenWords <= lenNext;
            if (lenNext == 16'd0 || lenNext > 16'(IMEM_WORDS)) begin
              state   <= ERR;
              loadErr <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (dataXfer) checksum <= checksum ^ byteIn;
          if (wordDone) begin
            imemWe    <= 1'b1;
            imemWdata <= asmWord;
            imemAddr  <= {wordCount[ADDR_W-3:0], 2'b00};
            wordCount <= wcNext;
            // Leaving DATA on the LEN-th word is what keeps wordCount saturated.
            if (16'(wcNext) == lenWords) state <= CHK;
          end
        end
        CHK: begin
          if (xfer) begin
            if (byteIn == checksum) begin
              state   <= DONE;
              coreRun <= 1'b1;
            end else begin
              state   <= ERR;
              loadErr <= 1'b1;
            end
          end
        end
        DONE, ERR: begin
        end
        default: begin
          state   <= ERR;
          loadErr <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frames are built from word lists and the
// expected writes/outcome are derived directly from the frame rules.
module tb_imem_loader;

  localparam int IMEM_WORDS = 64;
  localparam int ADDR_W     = 16;

  typedef logic [7:0]  byteQ_t[$];
  typedef logic [31:0] wordQ_t[$];

  logic              clk;
  logic              rst_n;
  logic [7:0]        byteIn;
  logic              byteValid;
  logic              byteReady;
  logic              imemWe;
  logic [ADDR_W-1:0] imemAddr;
  logic [31:0]       imemWdata;
  logic              coreRun;
  logic              loadErr;
  logic [ADDR_W-1:0] wordCount;

  int checkCnt = 0;
  int passCnt  = 0;

  logic [47:0] obsQ[$];

  imem_loader #(.IMEM_WORDS(IMEM_WORDS), .ADDR_W(ADDR_W), .MAGIC(8'hA5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .byteIn    (byteIn),
    .byteValid (byteValid),
    .byteReady (byteReady),
    .imemWe    (imemWe),
    .imemAddr  (imemAddr),
    .imemWdata (imemWdata),
    .coreRun   (coreRun),
    .loadErr   (loadErr),
    .wordCount (wordCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write strobe as {addr, data}.
  always @(negedge clk) begin
    if (rst_n && imemWe) obsQ.push_back({imemAddr, imemWdata});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCnt++;
    if (obs === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic checkResetOutputs(input string tag);
    chk({tag, ".byteReady"}, 64'(byteReady), 64'd0);
    chk({tag, ".imemWe"},    64'(imemWe),    64'd0);
    chk({tag, ".imemAddr"},  64'(imemAddr),  64'd0);
    chk({tag, ".imemWdata"}, 64'(imemWdata), 64'd0);
    chk({tag, ".coreRun"},   64'(coreRun),   64'd0);
    chk({tag, ".loadErr"},   64'(loadErr),   64'd0);
    chk({tag, ".wordCount"}, 64'(wordCount), 64'd0);
  endtask

  task automatic doReset(input string tag);
    byteValid = 1'b0;
    byteIn    = 8'd0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkResetOutputs({tag, ".rst"});
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk({tag, ".readyAfterRst"}, 64'(byteReady), 64'd1);
  endtask

  // Offer bytes in order; gapPct percent of cycles have byteValid low.
  // Stops early if the loader closes its input (byteReady=0) or after maxBytes.
  task automatic sendBytes(input string tag, input byteQ_t bq, input int gapPct,
                           input int maxBytes, output logic preRun);
    bit halted = 0;
    preRun = 1'b0;
    for (int i = 0; i < bq.size() && !halted && i < maxBytes; i++) begin
      bit   placed = 0;
      int   tries  = 0;
      while (!placed && !halted) begin
        @(negedge clk);
        if (!byteReady) begin
          byteValid = 1'b0;
          halted    = 1;
        end else if (int'($urandom_range(99)) < gapPct) begin
          byteValid = 1'b0;
        end else begin
          byteValid = 1'b1;
          byteIn    = bq[i];
          preRun    = coreRun;
          placed    = 1;
        end
        tries++;
        if (tries > 400 && !placed && !halted) begin
          chk({tag, ".sendTimeout"}, 64'd1, 64'd0);
          halted = 1;
        end
      end
    end
    @(negedge clk);
    byteValid = 1'b0;
  endtask

  function automatic logic [7:0] payloadXor(input wordQ_t words);
    logic [7:0] x = 8'd0;
    foreach (words[i]) x ^= words[i][7:0] ^ words[i][15:8] ^ words[i][23:16] ^ words[i][31:24];
    return x;
  endfunction

  function automatic byteQ_t buildFrame(input byteQ_t junk, input logic [15:0] lenField,
                                        input wordQ_t words, input bit badChk);
    byteQ_t bq = junk;
    bq.push_back(8'hA5);
    bq.push_back(lenField[7:0]);
    bq.push_back(lenField[15:8]);
    foreach (words[i]) for (int b = 0; b < 4; b++) bq.push_back(words[i][8*b +: 8]);
    bq.push_back(payloadXor(words) ^ {7'd0, badChk});
    return bq;
  endfunction

  task automatic runCase(input string name, input byteQ_t junk, input logic [15:0] lenField,
                         input wordQ_t words, input bit badChk, input int gapPct);
    byteQ_t bq;
    logic   preRun;
    bit     lenOk   = (lenField != 16'd0) && (int'(lenField) <= IMEM_WORDS);
    bit     expRun  = lenOk && !badChk;
    bit     expErr  = !expRun;
    int     expN    = lenOk ? int'(lenField) : 0;
    int     n;
    bq = buildFrame(junk, lenField, words, badChk);
    doReset(name);
    obsQ.delete();
    sendBytes(name, bq, gapPct, bq.size(), preRun);
    if (lenOk) begin
      chk({name, ".runBeforeChk"}, 64'(preRun), 64'd0);
      chk({name, ".runAfterChk"},  64'(coreRun), 64'(expRun));
    end
    repeat (3) @(negedge clk);
    chk({name, ".writes"}, 64'(obsQ.size()), 64'(expN));
    n = (obsQ.size() < expN) ? obsQ.size() : expN;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s.addr%0d", name, i), 64'(obsQ[i][47:32]), 64'(i * 4));
      chk($sformatf("%s.data%0d", name, i), 64'(obsQ[i][31:0]), 64'(words[i]));
    end
    chk({name, ".coreRun"},   64'(coreRun),   64'(expRun));
    chk({name, ".loadErr"},   64'(loadErr),   64'(expErr));
    chk({name, ".byteReady"}, 64'(byteReady), 64'd0);
    chk({name, ".wordCount"}, 64'(wordCount), 64'(expN));
    chk({name, ".lastAddr"},  64'(imemAddr),  64'(expN > 0 ? (expN - 1) * 4 : 0));
  endtask

  initial begin
    byteQ_t noJunk;
    byteQ_t junk;
    wordQ_t clean;
    wordQ_t full;
    wordQ_t rnd;
    byteQ_t partial;
    logic   dummy;

    rst_n     = 1'b0;
    byteValid = 1'b0;
    byteIn    = 8'd0;

    clean.push_back(32'h00A00513);
    clean.push_back(32'h00500593);

    runCase("clean",  noJunk, 16'd2, clean, 1'b0, 0);
    runCase("badChk", noJunk, 16'd2, clean, 1'b1, 0);
    runCase("len0",   noJunk, 16'h0000, clean, 1'b0, 0);
    runCase("len65",  noJunk, 16'h0041, clean, 1'b0, 0);

    junk.push_back(8'h00);
    junk.push_back(8'hFF);
    runCase("resync", junk, 16'd2, clean, 1'b0, 50);

    // Reset in the middle of the payload, then a full reload from address 0.
    partial = buildFrame(noJunk, 16'd2, clean, 1'b0);
    doReset("midLoad");
    sendBytes("midLoad", partial, 0, 8, dummy);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midLoad.held");
    runCase("reload", noJunk, 16'd2, clean, 1'b0, 0);

    for (int i = 0; i < IMEM_WORDS; i++) full.push_back(32'(i));
    runCase("fullDepth", noJunk, 16'(IMEM_WORDS), full, 1'b0, 0);

    for (int k = 0; k < 4; k++) begin
      int len = int'($urandom_range(1, IMEM_WORDS));
      rnd.delete();
      for (int i = 0; i < len; i++) rnd.push_back($urandom);
      runCase($sformatf("rand%0d", k), noJunk, 16'(len), rnd, 1'($urandom_range(1)), 30);
    end

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
